// File: rtl/rbz_spi_master.sv
// Mode-0 SPI master that shifts out one MSB-first frame of 1..DATA_W bits per start request.
// Done fires 1+HALF_DIV*(2N+2) cycles after the accepting edge; requests seen while busy are dropped.
module rbz_spi_master #(
  parameter  int DATA_W   = 80,
  parameter  int HALF_DIV = 2,
  localparam int CNT_W    = $clog2(DATA_W + 1),
  localparam int DIV_W    = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_start,
  input  logic [DATA_W-1:0] i_data,
  input  logic [CNT_W-1:0]  i_nbits,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_sclk,
  output logic              o_mosi,
  output logic              o_ss_n
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_HIGH,
    S_LOW,
    S_HOLD,
    S_GAP
  } state_t;

  state_t              r_state;
  logic [DIV_W-1:0]    r_div;
  logic [DATA_W-1:0]   r_shift;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_sclk;
  logic                r_mosi;
  logic                r_ss_n;
  logic                r_busy;
  logic                r_done;

  state_t              w_state_nxt;
  logic [DIV_W-1:0]    w_div_nxt;
  logic [DATA_W-1:0]   w_shift_nxt;
  logic [CNT_W-1:0]    w_cnt_nxt;
  logic                w_sclk_nxt;
  logic                w_mosi_nxt;
  logic                w_ss_n_nxt;
  logic                w_busy_nxt;
  logic                w_done_nxt;
  logic                w_div_last;
  logic [CNT_W-1:0]    w_nbits_clamped;

  assign w_div_last      = (r_div == DIV_W'(HALF_DIV - 1));
  assign w_nbits_clamped = (i_nbits > CNT_W'(DATA_W)) ? CNT_W'(DATA_W) : i_nbits;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_div   <= '0;
      r_shift <= '0;
      r_cnt   <= '0;
      r_sclk  <= 1'b0;
      r_mosi  <= 1'b0;
      r_ss_n  <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_div   <= w_div_nxt;
      r_shift <= w_shift_nxt;
      r_cnt   <= w_cnt_nxt;
      r_sclk  <= w_sclk_nxt;
      r_mosi  <= w_mosi_nxt;
      r_ss_n  <= w_ss_n_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // Outputs are computed one cycle ahead so every pin comes straight from a flop.
  always_comb begin
    w_state_nxt = r_state;
    w_div_nxt   = r_div;
    w_shift_nxt = r_shift;
    w_cnt_nxt   = r_cnt;
    w_sclk_nxt  = r_sclk;
    w_mosi_nxt  = r_mosi;
    w_ss_n_nxt  = r_ss_n;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;

    if (r_state != S_IDLE) begin
      w_div_nxt = w_div_last ? '0 : r_div + DIV_W'(1);
    end

    case (r_state)
      S_IDLE: begin
        if (i_start && (i_nbits != '0)) begin
          w_state_nxt = S_SETUP;
          w_div_nxt   = '0;
          w_shift_nxt = i_data;
          w_cnt_nxt   = w_nbits_clamped;
          w_sclk_nxt  = 1'b0;
          w_mosi_nxt  = i_data[DATA_W-1];
          w_ss_n_nxt  = 1'b0;
          w_busy_nxt  = 1'b1;
        end
      end
      S_SETUP: begin
        if (w_div_last) begin
          w_state_nxt = S_HIGH;
          w_sclk_nxt  = 1'b1;
        end
      end
      S_HIGH: begin
        if (w_div_last) begin
          w_cnt_nxt  = r_cnt - CNT_W'(1);
          w_sclk_nxt = 1'b0;
          if (r_cnt == CNT_W'(1)) begin
            w_state_nxt = S_HOLD;
          end else begin
            w_state_nxt = S_LOW;
            w_shift_nxt = {r_shift[DATA_W-2:0], 1'b0};
            w_mosi_nxt  = r_shift[DATA_W-2];
          end
        end
      end
      S_LOW: begin
        if (w_div_last) begin
          w_state_nxt = S_HIGH;
          w_sclk_nxt  = 1'b1;
        end
      end
      S_HOLD: begin
        if (w_div_last) begin
          w_state_nxt = S_GAP;
          w_ss_n_nxt  = 1'b1;
        end
      end
      S_GAP: begin
        if (w_div_last) begin
          w_state_nxt = S_IDLE;
          w_busy_nxt  = 1'b0;
          w_done_nxt  = 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign o_busy = r_busy;
  assign o_done = r_done;
  assign o_sclk = r_sclk;
  assign o_mosi = r_mosi;
  assign o_ss_n = r_ss_n;

endmodule

// File: tb/tb_rbz_spi_master.sv
// Bench for rbz_spi_master: three instances (HALF_DIV 2, 1, 3) checked every cycle against a
// frame-timeline model, plus a clock-rate SPI slave that captures the bits seen on each SCLK rise.
module tb_rbz_spi_master;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  st;
  logic [2:0]  busy, done, sclk, mosi, ssn;
  logic [79:0] dat [3];
  logic [6:0]  nb  [3];

  int nchk = 0;
  int nfail = 0;

  bit          act   [3];
  int          k     [3];
  int          mN    [3];
  logic [79:0] mD    [3];
  logic        lastm [3];

  logic        pss   [3];
  logic        psc   [3];
  logic [79:0] capv  [3];
  int          capn  [3];
  logic [79:0] lcapv [3];
  int          lcapn [3];
  int          dcnt  [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    rbz_spi_master #(
      .DATA_W  (80),
      .HALF_DIV((g == 0) ? 2 : ((g == 1) ? 1 : 3))
    ) u_dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_start(st[g]),
      .i_data (dat[g]),
      .i_nbits(nb[g]),
      .o_busy (busy[g]),
      .o_done (done[g]),
      .o_sclk (sclk[g]),
      .o_mosi (mosi[g]),
      .o_ss_n (ssn[g])
    );
  end

  initial forever #5 clk = ~clk;

  function automatic int hd(input int g);
    return (g == 0) ? 2 : ((g == 1) ? 1 : 3);
  endfunction

  function automatic logic [79:0] rnd80();
    logic [95:0] t;
    t = {$urandom(), $urandom(), $urandom()};
    return t[79:0];
  endfunction

  task automatic chk(input string nm, input int g, input logic [79:0] a, input logic [79:0] e);
    nchk++;
    if (a !== e) begin
      nfail++;
      $display("FAIL %s inst%0d: got %0h, expected %0h at %0t", nm, g, a, e, $time);
    end
  endtask

  task automatic go(input int g, input int n, input logic [79:0] d);
    @(posedge clk);
    #1;
    st[g] = 1'b1;
    nb[g] = 7'(n);
    dat[g] = d;
    @(posedge clk);
    #1;
    st[g] = 1'b0;
  endtask

  task automatic measure(input int g, input int n, output int ssf, output int ssl,
                         output int dn, output int bf, output int bl);
    ssf = -1; ssl = -1; dn = -1; bf = -1; bl = -1;
    for (int c = 1; c <= n; c++) begin
      @(negedge clk);
      if (!ssn[g]) begin
        if (ssf < 0) ssf = c;
        ssl = c;
      end
      if (busy[g]) begin
        if (bf < 0) bf = c;
        bl = c;
      end
      if (done[g] && dn < 0) dn = c;
    end
  endtask

  int          mh, tb_end, ph;
  logic        eb, ed, es, ec, em;
  int          ssf, ssl, dn, bf, bl, d0, d1, phase, hrun;
  logic [79:0] d, d2;

  initial begin
    rst_n = 1'b1;
    st = '0;
    for (int g = 0; g < 3; g++) begin
      dat[g] = '0; nb[g] = '0; act[g] = 0; k[g] = 0; mN[g] = 1; mD[g] = '0; lastm[g] = 0;
      pss[g] = 1; psc[g] = 0; capv[g] = '0; capn[g] = 0; lcapv[g] = '0; lcapn[g] = 0; dcnt[g] = 0;
    end
    #1 rst_n = 1'b0;

    fork
      // Model: each frame is a timeline indexed by cycles since the accepting edge.
      forever begin
        @(posedge clk);
        for (int g = 0; g < 3; g++) begin
          mh = hd(g);
          if (!rst_n) begin
            act[g] = 0; k[g] = 0; lastm[g] = 0;
          end else if ((!act[g] || k[g] >= mh * (2 * mN[g] + 2) + 1) && st[g] && nb[g] != 0) begin
            act[g] = 1; k[g] = 1;
            mN[g] = (nb[g] > 80) ? 80 : int'(nb[g]);
            mD[g] = dat[g];
            lastm[g] = dat[g][80 - mN[g]];
          end else if (act[g]) begin
            if (k[g] >= mh * (2 * mN[g] + 2) + 1) act[g] = 0;
            else k[g]++;
          end
        end
      end
      forever begin
        @(negedge clk);
        for (int g = 0; g < 3; g++) begin
          mh = hd(g);
          if (!rst_n) begin
            {eb, ed, es, ec, em} = 5'b00100;
          end else if (act[g]) begin
            tb_end = mh * (2 * mN[g] + 2);
            ph = (k[g] - 1) / mh;
            eb = (k[g] <= tb_end);
            ed = (k[g] == tb_end + 1);
            es = !(k[g] <= mh * (2 * mN[g] + 1));
            ec = (ph % 2 == 1) && (ph < 2 * mN[g]);
            em = (ph < 2 * mN[g]) ? mD[g][79 - ph / 2] : lastm[g];
          end else begin
            {eb, ed, es, ec, em} = {1'b0, 1'b0, 1'b1, 1'b0, lastm[g]};
          end
          chk("busy", g, 80'(busy[g]), 80'(eb));
          chk("done", g, 80'(done[g]), 80'(ed));
          chk("ss_n", g, 80'(ssn[g]), 80'(es));
          chk("sclk", g, 80'(sclk[g]), 80'(ec));
          chk("mosi", g, 80'(mosi[g]), 80'(em));
          if (pss[g] && !ssn[g]) begin
            capv[g] = '0; capn[g] = 0;
          end
          if (sclk[g] && !psc[g]) begin
            chk("sclk_rise_ss_n", g, 80'(ssn[g]), 80'(0));
            capv[g] = {capv[g][78:0], mosi[g]};
            capn[g]++;
          end
          if (ed) begin
            chk("bits_captured", g, 80'(capn[g]), 80'(mN[g]));
            chk("payload", g, capv[g], mD[g] >> (80 - mN[g]));
            lcapv[g] = capv[g]; lcapn[g] = capn[g];
          end
          if (done[g]) dcnt[g]++;
          pss[g] = ssn[g]; psc[g] = sclk[g];
        end
      end
    join_none

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst_ss_n", 0, 80'(ssn[0]), 80'(1));
    chk("rst_sclk", 0, 80'(sclk[0]), 80'(0));
    chk("rst_mosi", 0, 80'(mosi[0]), 80'(0));
    chk("rst_busy", 0, 80'(busy[0]), 80'(0));
    chk("rst_done", 0, 80'(done[0]), 80'(0));

    // 0xA5, 8 bits, HALF_DIV=2
    go(0, 8, {8'hA5, 72'h0});
    measure(0, 40, ssf, ssl, dn, bf, bl);
    chk("a5_ss_first", 0, 80'(ssf), 80'(1));
    chk("a5_ss_last", 0, 80'(ssl), 80'(34));
    chk("a5_done_at", 0, 80'(dn), 80'(37));
    chk("a5_busy_first", 0, 80'(bf), 80'(1));
    chk("a5_busy_last", 0, 80'(bl), 80'(36));
    chk("a5_nbits", 0, 80'(lcapn[0]), 80'(8));
    chk("a5_bits", 0, lcapv[0], 80'hA5);

    // single bit, HALF_DIV=1
    d = rnd80(); d[79] = 1'b1;
    go(1, 1, d);
    measure(1, 8, ssf, ssl, dn, bf, bl);
    chk("n1_ss_first", 1, 80'(ssf), 80'(1));
    chk("n1_ss_last", 1, 80'(ssl), 80'(3));
    chk("n1_done_at", 1, 80'(dn), 80'(5));
    chk("n1_nbits", 1, 80'(lcapn[1]), 80'(1));
    chk("n1_bits", 1, lcapv[1], 80'h1);

    // 74 bits, HALF_DIV=3
    d = rnd80();
    go(2, 74, d);
    repeat (460) @(posedge clk);
    chk("n74_nbits", 2, 80'(lcapn[2]), 80'(74));
    chk("n74_bits", 2, lcapv[2], d >> 6);

    // start mid-frame and nbits=0 while idle are both dropped
    d0 = dcnt[0]; d1 = dcnt[1];
    d = rnd80();
    go(0, 8, d);
    repeat (9) @(posedge clk);
    #1;
    st[0] = 1'b1; nb[0] = 7'd5; dat[0] = rnd80();
    st[1] = 1'b1; nb[1] = 7'd0;
    @(posedge clk);
    #1;
    st = '0;
    repeat (40) @(posedge clk);
    chk("ign_done_cnt", 0, 80'(dcnt[0] - d0), 80'(1));
    chk("ign_bits", 0, lcapv[0], 80'(d[79:72]));
    chk("nb0_done_cnt", 1, 80'(dcnt[1] - d1), 80'(0));

    // start held through done: back-to-back frames
    d0 = dcnt[0];
    @(posedge clk);
    #1;
    st[0] = 1'b1; nb[0] = 7'd4; dat[0] = rnd80();
    @(posedge clk);
    #1;
    phase = 0; hrun = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (phase == 0 && !ssn[0]) phase = 1;
      else if (phase == 1 && ssn[0]) begin phase = 2; hrun = 1; end
      else if (phase == 2 && ssn[0]) hrun++;
      else if (phase == 2 && !ssn[0]) begin phase = 3; st[0] = 1'b0; end
    end
    st[0] = 1'b0;
    chk("b2b_gap_cycles", 0, 80'(hrun), 80'(3));
    repeat (10) @(posedge clk);
    chk("b2b_done_cnt", 0, 80'(dcnt[0] - d0), 80'(2));

    // reset mid-frame
    d0 = dcnt[0];
    go(0, 16, rnd80());
    repeat (14) @(posedge clk);
    #1;
    chk("pre_rst_busy", 0, 80'(busy[0]), 80'(1));
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ss_n", 0, 80'(ssn[0]), 80'(1));
    chk("mid_rst_sclk", 0, 80'(sclk[0]), 80'(0));
    chk("mid_rst_mosi", 0, 80'(mosi[0]), 80'(0));
    chk("mid_rst_busy", 0, 80'(busy[0]), 80'(0));
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (5) @(posedge clk);
    chk("rst_no_done", 0, 80'(dcnt[0] - d0), 80'(0));
    d2 = rnd80();
    go(0, 16, d2);
    repeat (75) @(posedge clk);
    chk("post_rst_done", 0, 80'(dcnt[0] - d0), 80'(1));
    chk("post_rst_bits", 0, lcapv[0], 80'(d2[79:64]));

    // random traffic, including nbits 0 and values above 80
    for (int c = 0; c < 2500; c++) begin
      @(posedge clk);
      #1;
      for (int g = 0; g < 3; g++) begin
        if ($urandom_range(0, 7) == 0) begin
          st[g] = 1'b1;
          nb[g] = 7'($urandom_range(0, 100));
          dat[g] = rnd80();
        end else begin
          st[g] = 1'b0;
        end
      end
    end
    @(posedge clk);
    #1;
    st = '0;
    for (int c = 0; c < 1500 && busy != 3'b000; c++) @(posedge clk);
    #1;
    chk("drain_idle", 0, 80'(busy), 80'(0));
    repeat (3) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nfail);
    $finish;
  end

endmodule

// File: doc/rbz_spi_master.md
# rbz_spi_master

SPI mode-0 master that drives the three-wire register-write port of the rbzero raycaster core (sclk, mosi, ss_n). It shifts out one framed payload of 1..DATA_W bits per request, MSB first. It sits in the test-harness/companion-controller side of the design: its outputs connect to the chip's `ui_in[0]` (sclk), `ui_in[1]` (mosi) and `ui_in[2]` (ss_n). A simple start/busy/done handshake lets a sequencer or testbench stream vector, view and map-config updates into rbzero.

## Interface
- `DATA_W`, 80: width of payload buffer; first bit sent is `i_data[DATA_W-1]`.
- `HALF_DIV`, 2: clk cycles per SCLK half-period; legal range ≥1.
- `clk` in 1: system clock; all logic on rising edge.
- `rst_n` in 1: reset is asynchronous and active-low.
- `i_start` in 1: request pulse; sampled only while `o_busy`=0.
- `i_data` in DATA_W: payload, left-aligned (MSB-first).
- `i_nbits` in 7 (ceil log2(DATA_W+1)): number of bits to send.
- `o_busy` out 1: transaction in progress.
- `o_done` out 1: one-cycle pulse when the transaction completes.
- `o_sclk` out 1: SPI clock, idles low.
- `o_mosi` out 1: SPI data, changes only while SCLK is low.
- `o_ss_n` out 1: active-low frame select.

## Operation
- All outputs are registered. Reset values: `o_ss_n`=1, `o_sclk`=0, `o_mosi`=0, `o_busy`=0, `o_done`=0, state IDLE, shift register 0, bit count 0, divider 0.
- Shift register is DATA_W wide. Bit counter counts down. Divider counts 0..HALF_DIV-1; each state below lasts exactly HALF_DIV cycles unless noted.
- IDLE: `o_ss_n`=1, `o_sclk`=0, `o_busy`=0.
  - On `i_start`=1 with 1≤`i_nbits`≤DATA_W: latch `i_data` and `i_nbits`, then go to SETUP.
  - `i_nbits`=0: request ignored. No busy, no done.
  - `i_nbits`>DATA_W: clamped to DATA_W.
- SETUP: `o_ss_n`=0, `o_sclk`=0, `o_mosi`=shift[DATA_W-1], `o_busy`=1. Then go to HIGH.
- HIGH: `o_sclk`=1; the receiver samples MOSI on this rising edge. On the last cycle, decrement the count.
  - Count reaches 0: go to HOLD.
  - Otherwise: shift left by 1 and go to LOW.
- LOW: `o_sclk`=0, `o_mosi`=new shift[DATA_W-1]. Then go to HIGH.
- HOLD: `o_sclk`=0, `o_ss_n`=0. This holds the frame after the last edge. Then go to GAP.
- GAP: `o_ss_n`=1, `o_busy`=1. This provides the minimum deselect time. Then go to IDLE with `o_done`=1 and `o_busy`=0 in that same cycle.
- `i_start` while `o_busy`=1 is ignored; there is no queueing. `i_data` and `i_nbits` may change freely after acceptance.
- In the `o_done` cycle the block is IDLE, so `i_start` is accepted there for back-to-back frames.
- `rst_n` low mid-transaction immediately forces all outputs to their reset values. SS_n rising aborts the frame at the receiver. No done pulse is issued.

## Timing
- Take start as sampled at edge 0. Then:
  - `o_ss_n` falls and `o_busy` rises in cycle 1.
  - First SCLK rise is at cycle 1+H, where H=HALF_DIV.
- N bits produce exactly N SCLK rising edges.
- `o_ss_n` is low for H·(2N+1) cycles, followed by H cycles of GAP.
- `o_done` fires at cycle 1+H·(2N+2). Busy is high for H·(2N+2) cycles.
- MOSI setup before each SCLK rise is H cycles. Hold after each rise is H cycles. With HALF_DIV=1, SCLK = clk/2.

## Test plan
- HALF_DIV=2, N=8, data=0xA5 left-aligned:
  - Sampled MOSI on 8 SCLK rises = 1,0,1,0,0,1,0,1.
  - ss_n low cycles 1..34.
  - done pulse at cycle 37, busy cycles 1..36.
- N=1, HALF_DIV=1, data MSB=1: one SCLK rise with MOSI=1, ss_n low 3 cycles, done at cycle 5.
- N=74 random payload, HALF_DIV=3: a behavioural SPI slave model captures exactly 74 bits matching `i_data[79:6]`, and no extra SCLK edges occur.
- `i_start` pulsed at cycle 10 of an active frame, and `i_nbits`=0 while idle:
  - Neither is accepted.
  - The frame is unchanged and no second done pulse occurs.
- Start held high through done: a second frame begins the cycle after done, and ss_n stays high for exactly H+1 cycles between frames.
- `rst_n` asserted at cycle 15 of an N=16 frame:
  - Outputs immediately read ss_n=1, sclk=0, mosi=0, busy=0.
  - No done pulse.
  - After release, a fresh start transmits correctly.
